// File: rtl/soreg_issue_ctrl_if.sv
// Bus bundle for soreg_issue_ctrl: instruction handshake, ALU issue/result and display outputs.
// The slave modport is the controller; master is the instruction source plus ALU side.
`timescale 1ns/1ps
interface soreg_issue_ctrl_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_valid;
    logic [DATA_W-1:0] alu_result;
    logic              alu_done;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              busy;
    logic              err;

    // Handshakes: an instruction transfers on the clock edge where instr_valid && instr_ready;
    // alu_valid is a one-cycle issue strobe and alu_result is taken on the edge where alu_done=1.
    modport slave (
        input  instr, instr_valid, alu_result, alu_done,
        output instr_ready, alu_op, alu_a, alu_b, alu_valid,
        disp_data, disp_valid, busy, err
    );

    modport master (
        output instr, instr_valid, alu_result, alu_done,
        input  instr_ready, alu_op, alu_a, alu_b, alu_valid,
        disp_data, disp_valid, busy, err
    );
endinterface

// File: rtl/soreg_issue_ctrl.sv
// Decode/issue controller: 8x16 register file, local LOAD/CLEAR/DPS, ALU issue and writeback.
// Optional macro ALU_TIMEOUT_EN adds a WAIT-state timeout with a sticky err flag.
`timescale 1ns/1ps
module soreg_issue_ctrl #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    soreg_issue_ctrl_if.slave   bus,
    output logic [2:0]          o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_ADDI  = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_SUBI  = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_CLEAR = 3'd6;
    localparam logic [2:0] OP_DPS   = 3'd7;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("soreg_issue_ctrl: TIMEOUT must be at least 1");
    end

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_instr;
    logic [DATA_W-1:0] r_regs [8];
    logic [2:0]        r_alu_op;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_disp;
    logic              r_disp_valid;

    logic [2:0]        w_op;
    logic [2:0]        w_rd;
    logic [2:0]        w_rs1;
    logic [2:0]        w_rs2;
    logic [DATA_W-1:0] w_imm_sext;
    logic              w_is_alu;
    logic              w_uses_imm;
    logic              w_accept;
    logic              w_timeout;
    logic              w_instr_ready;
    logic              w_alu_valid;
    logic              w_busy;

    // Fields always come from the captured word, never from the live bus.
    assign w_op       = r_instr[15:13];
    assign w_rd       = r_instr[12:10];
    assign w_rs1      = r_instr[9:7];
    assign w_rs2      = r_instr[6:4];
    assign w_imm_sext = {{(DATA_W-7){r_instr[6]}}, r_instr[6:0]};
    assign w_is_alu   = (w_op == OP_ADD) || (w_op == OP_ADDI) || (w_op == OP_SUB) ||
                        (w_op == OP_SUBI) || (w_op == OP_MULT);
    assign w_uses_imm = (w_op == OP_ADDI) || (w_op == OP_SUBI);
    assign w_accept   = bus.instr_valid && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_instr_ready = 1'b0;
        w_alu_valid   = 1'b0;
        w_busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_instr_ready = 1'b1;
                w_busy        = 1'b0;
                if (bus.instr_valid) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = w_is_alu ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: begin
                w_alu_valid = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                if (bus.alu_done) begin
                    w_next = S_WB;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_WB: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operands are sampled in DECODE, so rd==rs1/rs2 sees the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
            r_instr      <= '0;
            r_alu_op     <= OP_LOAD;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_result     <= '0;
            r_disp       <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_instr <= bus.instr;
                    end
                end
                S_DECODE: begin
                    case (w_op)
                        OP_LOAD:  r_regs[w_rd] <= w_imm_sext;
                        OP_CLEAR: r_regs[w_rd] <= '0;
                        OP_DPS: begin
                            r_disp       <= r_regs[w_rs1];
                            r_disp_valid <= 1'b1;
                        end
                        default: begin
                            r_alu_op <= w_op;
                            r_alu_a  <= r_regs[w_rs1];
                            r_alu_b  <= w_uses_imm ? w_imm_sext : r_regs[w_rs2];
                        end
                    endcase
                end
                S_WAIT: begin
                    if (bus.alu_done) begin
                        r_result <= bus.alu_result;
                    end
                end
                S_WB: begin
                    r_regs[w_rd] <= r_result;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;

    // The count indexes WAIT cycles from zero, so done on the TIMEOUT-th cycle still wins.
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (!bus.alu_done) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
                if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign bus.err = r_err;
`else
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    assign bus.instr_ready = w_instr_ready;
    assign bus.alu_valid   = w_alu_valid;
    assign bus.busy        = w_busy;
    assign bus.alu_op      = r_alu_op;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.disp_data   = r_disp;
    assign bus.disp_valid  = r_disp_valid;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_soreg_issue_ctrl.sv
// Bench for soreg_issue_ctrl: directed vector table, reset/timeout sequences and random
// instructions checked against an instruction-level register-file model.
`timescale 1ns/1ps
module tb_soreg_issue_ctrl;

    localparam int TB_TIMEOUT = 4;

    typedef struct {
        logic        is_alu;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        is_dps;
        logic [15:0] disp;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        int          dly;
        exp_t        e;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    soreg_issue_ctrl_if #(.DATA_W(16)) bus_if ();

    soreg_issue_ctrl #(.DATA_W(16), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] ref_regs [8];
    logic [15:0] exp_q [$];
    vec_t        vecs [18];

    logic        o_saw_alu;
    logic [2:0]  o_op;
    logic [15:0] o_a, o_b, o_disp;
    int          o_ndisp, o_kdisp, o_kvalid, o_kidle, o_kdone;
    logic        o_stable, o_prot;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic exp_t mk_loc();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic exp_t mk_alu(input logic [2:0] op, input logic [15:0] a, b, res);
        exp_t e;
        e = '{default: '0};
        e.is_alu = 1'b1; e.op = op; e.a = a; e.b = b; e.res = res;
        return e;
    endfunction

    function automatic exp_t mk_dps(input logic [15:0] v);
        exp_t e;
        e = '{default: '0};
        e.is_dps = 1'b1; e.disp = v;
        return e;
    endfunction

    // Instruction-level model: what the register file and ALU port should see per instruction.
    task automatic model_exec(input logic [15:0] w, output exp_t e);
        logic [2:0]  op;
        int          rd, rs1, rs2;
        logic [15:0] imm16, a, b;
        logic [31:0] full;
        op = w[15:13]; rd = int'(w[12:10]); rs1 = int'(w[9:7]); rs2 = int'(w[6:4]);
        imm16 = 16'($signed(w[6:0]));
        e = '{default: '0};
        if (op == 3'd0) ref_regs[rd] = imm16;
        else if (op == 3'd6) ref_regs[rd] = 16'd0;
        else if (op == 3'd7) begin
            e.is_dps = 1'b1; e.disp = ref_regs[rs1];
        end else begin
            a = ref_regs[rs1];
            b = (op == 3'd2 || op == 3'd4) ? imm16 : ref_regs[rs2];
            if (op == 3'd1 || op == 3'd2) full = 32'(a) + 32'(b);
            else if (op == 3'd5) full = 32'(a) * 32'(b);
            else full = 32'(a) - 32'(b);
            e.is_alu = 1'b1; e.op = op; e.a = a; e.b = b; e.res = full[15:0];
            ref_regs[rd] = full[15:0];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.instr_valid = 1'b0; bus_if.alu_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
    endtask

    // ---------------- driver: one instruction, acting as the ALU ----------------
    task automatic run_instr(input logic [15:0] w, input logic [15:0] res, input int dly,
                             input logic noise);
        int k, n_valid, wait_n;
        o_saw_alu = 1'b0; o_op = '0; o_a = '0; o_b = '0; o_disp = '0;
        o_ndisp = 0; o_kdisp = -1; o_kvalid = -1; o_kidle = -1; o_kdone = -1;
        o_stable = 1'b1; o_prot = 1'b1; n_valid = 0;
        bus_if.instr = w; bus_if.instr_valid = 1'b1;
        wait_n = 0;
        while (bus_if.instr_ready !== 1'b1 && wait_n < 50) begin
            @(negedge clk); wait_n++;
        end
        if (bus_if.instr_ready !== 1'b1) begin
            bus_if.instr_valid = 1'b0; o_prot = 1'b0;
            return;
        end
        @(posedge clk);
        k = 0;
        while (o_kidle < 0 && k < 300) begin
            @(negedge clk); k++;
            if (bus_if.alu_valid === 1'b1) begin
                n_valid++;
                if (!o_saw_alu) begin
                    o_saw_alu = 1'b1; o_op = bus_if.alu_op; o_a = bus_if.alu_a; o_b = bus_if.alu_b;
                    o_kvalid = k; o_kdone = k + dly;
                end
            end else if (o_saw_alu && k <= o_kdone &&
                         (bus_if.alu_op !== o_op || bus_if.alu_a !== o_a || bus_if.alu_b !== o_b)) begin
                o_stable = 1'b0;
            end
            if (bus_if.disp_valid === 1'b1) begin
                o_ndisp++; o_disp = bus_if.disp_data; o_kdisp = k;
            end
            if (bus_if.busy === bus_if.instr_ready) o_prot = 1'b0;
            if (bus_if.busy === 1'b0) o_kidle = k;
            bus_if.alu_done    = o_saw_alu && (k == o_kdone);
            bus_if.alu_result  = res;
            bus_if.instr_valid = noise && o_saw_alu && (k < o_kdone);
            bus_if.instr       = (noise && o_saw_alu) ? 16'h1C01 : w;
        end
        bus_if.alu_done = 1'b0; bus_if.instr_valid = 1'b0;
        if (n_valid > 1) o_stable = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [15:0] w, input exp_t e,
                                 input int dly, input logic noise);
        run_instr(w, e.res, dly, noise);
        chk({tag, " alu_issued"}, 32'(o_saw_alu), 32'(e.is_alu));
        if (e.is_alu) begin
            chk({tag, " alu_op"}, 32'(o_op), 32'(e.op));
            chk({tag, " alu_a"}, 32'(o_a), 32'(e.a));
            chk({tag, " alu_b"}, 32'(o_b), 32'(e.b));
            chk({tag, " alu_valid_cycle"}, 32'(o_kvalid), 32'd2);
            chk({tag, " idle_after_done"}, 32'(o_kidle), 32'(o_kdone + 2));
            chk({tag, " alu_hold_and_pulse"}, 32'(o_stable), 32'd1);
        end else begin
            chk({tag, " local_idle_cycle"}, 32'(o_kidle), 32'd2);
        end
        chk({tag, " disp_pulses"}, 32'(o_ndisp), e.is_dps ? 32'd1 : 32'd0);
        if (e.is_dps) begin
            chk({tag, " disp_data"}, 32'(o_disp), 32'(e.disp));
            chk({tag, " disp_cycle"}, 32'(o_kdisp), 32'd2);
        end
        chk({tag, " ready_busy_protocol"}, 32'(o_prot), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " instr_ready"}, 32'(bus_if.instr_ready), 32'd1);
        chk({tag, " busy"}, 32'(bus_if.busy), 32'd0);
        chk({tag, " alu_valid"}, 32'(bus_if.alu_valid), 32'd0);
        chk({tag, " alu_op"}, 32'(bus_if.alu_op), 32'd0);
        chk({tag, " alu_a"}, 32'(bus_if.alu_a), 32'd0);
        chk({tag, " alu_b"}, 32'(bus_if.alu_b), 32'd0);
        chk({tag, " disp_data"}, 32'(bus_if.disp_data), 32'd0);
        chk({tag, " disp_valid"}, 32'(bus_if.disp_valid), 32'd0);
        chk({tag, " err"}, 32'(bus_if.err), 32'd0);
        chk({tag, " dbg_idle"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        exp_t        e;
        logic [15:0] w;
        int          dly;

        vecs[0]  = '{16'h057D, 0, mk_loc()};                                  // LOAD r1,#-3
        vecs[1]  = '{16'hE080, 0, mk_dps(16'hFFFD)};                          // DPS r1
        vecs[2]  = '{16'h0405, 0, mk_loc()};                                  // LOAD r1,#5
        vecs[3]  = '{16'h0807, 0, mk_loc()};                                  // LOAD r2,#7
        vecs[4]  = '{16'h2CA0, 3, mk_alu(3'd1, 16'h0005, 16'h0007, 16'h000C)}; // ADD r3,r1,r2
        vecs[5]  = '{16'hE180, 0, mk_dps(16'h000C)};                          // DPS r3
        vecs[6]  = '{16'h047F, 0, mk_loc()};                                  // LOAD r1,#-1
        vecs[7]  = '{16'h84FF, 1, mk_alu(3'd4, 16'hFFFF, 16'hFFFF, 16'h0000)}; // SUBI r1,r1,#-1
        vecs[8]  = '{16'hE080, 0, mk_dps(16'h0000)};                          // DPS r1
        vecs[9]  = '{16'h51BF, 2, mk_alu(3'd2, 16'h000C, 16'h003F, 16'h004B)}; // ADDI r4,r3,#63
        vecs[10] = '{16'hCC00, 0, mk_loc()};                                  // CLEAR r3
        vecs[11] = '{16'hE180, 0, mk_dps(16'h0000)};                          // DPS r3
        vecs[12] = '{16'hB640, 4, mk_alu(3'd5, 16'h004B, 16'h004B, 16'h15F9)}; // MULT r5,r4,r4
        vecs[13] = '{16'h79D0, 1, mk_alu(3'd3, 16'h0000, 16'h15F9, 16'hEA07)}; // SUB r6,r3,r5
        vecs[14] = '{16'hE300, 0, mk_dps(16'hEA07)};                          // DPS r6
        vecs[15] = '{16'hE280, 0, mk_dps(16'h15F9)};                          // DPS r5
        vecs[16] = '{16'h0040, 0, mk_loc()};                                  // LOAD r0,#-64
        vecs[17] = '{16'hE000, 0, mk_dps(16'hFFC0)};                          // DPS r0

        bus_if.instr = '0; bus_if.instr_valid = 1'b0;
        bus_if.alu_result = '0; bus_if.alu_done = 1'b0;
        @(negedge clk);
        do_reset();
        check_reset_outputs("reset");

        for (int i = 0; i < 18; i++) begin
            model_exec(vecs[i].instr, e);
            run_and_check($sformatf("vec%0d", i), vecs[i].instr, vecs[i].e, vecs[i].dly,
                          vecs[i].e.is_alu);
        end

        // Reset while waiting on the ALU; a late alu_done must not write back.
        model_exec(16'h0809, e);
        run_and_check("load_r2_9", 16'h0809, e, 0, 1'b0);
        bus_if.instr = 16'h2920; bus_if.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); bus_if.instr_valid = 1'b0;
        @(negedge clk);
        chk("rstwait alu_valid", 32'(bus_if.alu_valid), 32'd1);
        chk("rstwait alu_a", 32'(bus_if.alu_a), 32'h9);
        @(negedge clk);
        chk("rstwait busy", 32'(bus_if.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus_if.alu_done = 1'b1; bus_if.alu_result = 16'h1234;
        @(negedge clk);
        bus_if.alu_done = 1'b0;
        check_reset_outputs("after_abort");
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
        model_exec(16'hE100, e);
        run_and_check("abort_r2", 16'hE100, e, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            w   = 16'($urandom_range(0, 16'hFFFF));
            dly = $urandom_range(1, 4);
            model_exec(w, e);
            run_and_check($sformatf("rnd%0d_%04h", n, w), w, e, dly, 1'($urandom_range(0, 1)));
        end

`ifdef ALU_TIMEOUT_EN
        // MULT with no alu_done: error after TB_TIMEOUT WAIT cycles and rd keeps its value.
        model_exec(16'h1403, e);
        run_and_check("to_load_r5", 16'h1403, e, 0, 1'b0);
        bus_if.instr = 16'hB6D0; bus_if.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); bus_if.instr_valid = 1'b0;
        @(negedge clk);
        chk("to alu_valid", 32'(bus_if.alu_valid), 32'd1);
        repeat (TB_TIMEOUT) @(negedge clk);
        chk("to err_before", 32'(bus_if.err), 32'd0);
        chk("to busy_last_wait", 32'(bus_if.busy), 32'd1);
        @(negedge clk);
        chk("to err_set", 32'(bus_if.err), 32'd1);
        chk("to idle", 32'(bus_if.instr_ready), 32'd1);
        model_exec(16'hE280, e);
        run_and_check("to_r5_kept", 16'hE280, e, 0, 1'b0);
        model_exec(16'h2CA0, e);
        run_and_check("to_done_at_limit", 16'h2CA0, e, TB_TIMEOUT, 1'b0);
        chk("to err_sticky", 32'(bus_if.err), 32'd1);
        do_reset();
        chk("to err_cleared", 32'(bus_if.err), 32'd0);
`endif

        // Final register dump through DPS against the model.
        for (int r = 0; r < 8; r++) exp_q.push_back(ref_regs[r]);
        for (int r = 0; r < 8; r++) begin
            run_instr({3'd7, 3'd0, 3'(r), 7'd0}, 16'd0, 1, 1'b0);
            chk($sformatf("dump r%0d", r), 32'(o_disp), 32'(exp_q.pop_front()));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
